// File: rtl/acc_cpu_pkg.sv
// acc_cpu_pkg: opcodes, FSM states and decode helpers shared by the accumulator CPU
package acc_cpu_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_XOR  = 4'h6;
    localparam logic [3:0] OP_NOT  = 4'h7;
    localparam logic [3:0] OP_SHL  = 4'h8;
    localparam logic [3:0] OP_SHR  = 4'h9;
    localparam logic [3:0] OP_HALT = 4'hA;
    localparam logic [3:0] OP_JMP  = 4'hB;
    localparam logic [3:0] OP_JZ   = 4'hC;
    localparam logic [3:0] OP_JC   = 4'hD;
    localparam logic [3:0] OP_STA  = 4'hE;
    localparam logic [3:0] OP_LDA  = 4'hF;

    typedef enum logic [2:0] {IDLE, FETCH, OPERAND, EXEC, HALT} state_t;

    // Takes the low nibble only; callers must reject opcodes with upper bits set.
    function automatic logic is_two_byte(input logic [3:0] op);
        return (op >= OP_LDI && op <= OP_XOR) || op >= OP_JMP;
    endfunction

endpackage

// File: rtl/acc_cpu_if.sv
// acc_cpu_if: program-load/run controls and architectural status of the accumulator CPU
interface acc_cpu_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
);
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [DATA_W-1:0] prog_data;
    logic              run;
    logic [DATA_W-1:0] acc;
    logic [ADDR_W-1:0] pc;
    logic              zero;
    logic              carry;
    logic              busy;
    logic              halted;
    logic              illegal;

    modport master (
        output prog_we, prog_addr, prog_data, run,
        input  acc, pc, zero, carry, busy, halted, illegal
    );

    modport slave (
        input  prog_we, prog_addr, prog_data, run,
        output acc, pc, zero, carry, busy, halted, illegal
    );
endinterface

// File: rtl/acc_cpu_alu.sv
// acc_cpu_alu: combinational datapath computing the accumulator result and flag updates
module acc_cpu_alu
    import acc_cpu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] acc,
    input  logic [DATA_W-1:0] operand,
    input  logic [DATA_W-1:0] opcode,
    input  logic              carry_in,
    output logic [DATA_W-1:0] result,
    output logic              carry_out,
    output logic              zero_out,
    output logic              writes_acc,
    output logic              writes_carry
);
    logic          legal;
    logic [3:0]    op;
    logic [DATA_W:0] sum;
    logic [DATA_W:0] diff;

    assign op    = opcode[3:0];
    assign legal = (opcode >> 4) == '0;
    assign sum   = {1'b0, acc} + {1'b0, operand};
    // The extra bit of an unsigned subtraction is exactly the borrow.
    assign diff  = {1'b0, acc} - {1'b0, operand};

    always_comb begin
        result       = acc;
        carry_out    = carry_in;
        writes_acc   = 1'b0;
        writes_carry = 1'b0;
        if (legal) begin
            case (op)
                OP_LDI, OP_LDA: begin result = operand; writes_acc = 1'b1; end
                OP_ADD: begin {carry_out, result} = sum;  writes_acc = 1'b1; writes_carry = 1'b1; end
                OP_SUB: begin {carry_out, result} = diff; writes_acc = 1'b1; writes_carry = 1'b1; end
                OP_AND: begin result = acc & operand; writes_acc = 1'b1; end
                OP_OR:  begin result = acc | operand; writes_acc = 1'b1; end
                OP_XOR: begin result = acc ^ operand; writes_acc = 1'b1; end
                OP_NOT: begin result = ~acc; writes_acc = 1'b1; end
                OP_SHL: begin result = acc << 1; carry_out = acc[DATA_W-1]; writes_acc = 1'b1; writes_carry = 1'b1; end
                OP_SHR: begin result = acc >> 1; carry_out = acc[0]; writes_acc = 1'b1; writes_carry = 1'b1; end
                default: ;
            endcase
        end
    end

    assign zero_out = result == '0;
endmodule

// File: rtl/acc_cpu_core.sv
// acc_cpu_core: fetch/operand/execute FSM, registers and program/data memory
module acc_cpu_core
    import acc_cpu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
) (
    input  logic     clk,
    input  logic     rst_n,
    acc_cpu_if.slave bus
);
    logic [DATA_W-1:0] mem [2**ADDR_W];
    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] opcode;
    logic [DATA_W-1:0] operand;
    logic              zero;
    logic              carry;
    logic              illegal;

    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] result;
    logic              carry_out;
    logic              zero_out;
    logic              writes_acc;
    logic              writes_carry;
    logic              legal;
    logic              rd_legal;
    logic              taken;
    logic              idle_like;
    logic [3:0]        op;

    assign op        = opcode[3:0];
    assign legal     = (opcode >> 4) == '0;
    assign rd_data   = mem[pc];
    assign rd_legal  = (rd_data >> 4) == '0;
    assign idle_like = state == IDLE || state == HALT;
    assign alu_b     = (legal && op == OP_LDA) ? mem[operand[ADDR_W-1:0]] : operand;
    assign taken     = legal && (op == OP_JMP || (op == OP_JZ && zero) || (op == OP_JC && carry));

    acc_cpu_alu #(.DATA_W(DATA_W)) alu (
        .acc          (acc),
        .operand      (alu_b),
        .opcode       (opcode),
        .carry_in     (carry),
        .result       (result),
        .carry_out    (carry_out),
        .zero_out     (zero_out),
        .writes_acc   (writes_acc),
        .writes_carry (writes_carry)
    );

    // Memory is deliberately outside the reset domain so programs survive rst_n.
    always_ff @(posedge clk) begin
        if (idle_like && bus.prog_we)
            mem[bus.prog_addr] <= bus.prog_data;
        else if (state == EXEC && legal && op == OP_STA)
            mem[operand[ADDR_W-1:0]] <= acc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pc      <= '0;
            acc     <= '0;
            opcode  <= '0;
            operand <= '0;
            zero    <= 1'b0;
            carry   <= 1'b0;
            illegal <= 1'b0;
        end else begin
            case (state)
                IDLE, HALT: begin
                    if (!bus.prog_we && bus.run) begin
                        state   <= FETCH;
                        pc      <= '0;
                        acc     <= '0;
                        zero    <= 1'b0;
                        carry   <= 1'b0;
                        illegal <= 1'b0;
                    end
                end
                FETCH: begin
                    opcode <= rd_data;
                    pc     <= pc + 1'b1;
                    state  <= (rd_legal && is_two_byte(rd_data[3:0])) ? OPERAND : EXEC;
                end
                OPERAND: begin
                    operand <= rd_data;
                    pc      <= pc + 1'b1;
                    state   <= EXEC;
                end
                EXEC: begin
                    if (writes_acc) begin
                        acc  <= result;
                        zero <= zero_out;
                    end
                    if (writes_carry) carry <= carry_out;
                    if (taken) pc <= operand[ADDR_W-1:0];
                    if (!legal) illegal <= 1'b1;
                    state <= (!legal || op == OP_HALT) ? HALT : FETCH;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.acc     = acc;
    assign bus.pc      = pc;
    assign bus.zero    = zero;
    assign bus.carry   = carry;
    assign bus.busy    = state == FETCH || state == OPERAND || state == EXEC;
    assign bus.halted  = state == HALT;
    assign bus.illegal = illegal;
endmodule
